// File: rtl/psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulator: beat descriptor and
// payload field positions, int8 saturation limits and small decode helpers.
package psum_acc_pkg;

  // Beat descriptor (mac_array2psum_acc_info) field positions.
  localparam int INFO_W    = 32;
  localparam int PIX_LSB   = 0;
  localparam int PIX_MSB   = 15;
  localparam int OCH_LSB   = 16;
  localparam int OCH_MSB   = 23;
  localparam int FIRST_BIT = 24;
  localparam int LAST_BIT  = 25;
  localparam int EOC_BIT   = 26;

  // Beat payload (mac_array2psum_acc_data) field positions.
  localparam int DATA_W = 64;
  localparam int P3_LSB = 0;
  localparam int P3_MSB = 31;
  localparam int P1_LSB = 32;
  localparam int P1_MSB = 55;
  localparam int ID_LSB = 56;
  localparam int ID_MSB = 63;

  // Requantized output range.
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  // Decoded descriptor; the reserved bits [31:27] are not carried.
  typedef struct packed {
    logic        eoc;
    logic        last;
    logic        first;
    logic [7:0]  och;
    logic [15:0] pix;
  } beat_info_t;

  // Decoded payload; fields are raw two's-complement bit patterns.
  typedef struct packed {
    logic [7:0]  id;
    logic [23:0] p1;
    logic [31:0] p3;
  } beat_data_t;

  function automatic beat_info_t decode_info(input logic [EOC_BIT:0] info);
    beat_info_t b;
    b.pix   = info[PIX_MSB:PIX_LSB];
    b.och   = info[OCH_MSB:OCH_LSB];
    b.first = info[FIRST_BIT];
    b.last  = info[LAST_BIT];
    b.eoc   = info[EOC_BIT];
    return b;
  endfunction

  function automatic beat_data_t decode_data(input logic [DATA_W-1:0] data);
    beat_data_t d;
    d.id = data[ID_MSB:ID_LSB];
    d.p1 = data[P1_MSB:P1_LSB];
    d.p3 = data[P3_MSB:P3_LSB];
    return d;
  endfunction

  // omap write address: {8'b0, out_ch, pixel}.
  function automatic logic [31:0] omap_addr(input logic [7:0] och, input logic [15:0] pix);
    return {8'h00, och, pix};
  endfunction

endpackage

// File: rtl/psum_acc_if.sv
// Beat input channel from the MAC array and omap write channel, bundled.
// The master side is the environment (MAC array plus omap buffer); the slave
// side is psum_acc.
interface psum_acc_if;
  import psum_acc_pkg::*;

  logic [INFO_W-1:0] mac_array2psum_acc_info;
  logic [DATA_W-1:0] mac_array2psum_acc_data;
  logic              mac_array2psum_acc_vld;
  logic              mac_array2psum_acc_rdy;

  logic [31:0]       omap_waddr;
  logic [7:0]        omap_wdata;
  logic              omap_wvld;
  logic              omap_wrdy;

  modport master (
    output mac_array2psum_acc_info,
    output mac_array2psum_acc_data,
    output mac_array2psum_acc_vld,
    input  mac_array2psum_acc_rdy,
    input  omap_waddr,
    input  omap_wdata,
    input  omap_wvld,
    output omap_wrdy
  );

  modport slave (
    input  mac_array2psum_acc_info,
    input  mac_array2psum_acc_data,
    input  mac_array2psum_acc_vld,
    output mac_array2psum_acc_rdy,
    output omap_waddr,
    output omap_wdata,
    output omap_wvld,
    input  omap_wrdy
  );

endinterface

// File: rtl/psum_buf.sv
// Partial-sum buffer: DEPTH x W, one read and one write port, synchronous
// read. Read data holds its value on cycles without a read. A same-cycle
// read and write of one address returns the old contents; the caller
// forwards the new value itself.
module psum_buf #(
  parameter int W      = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data
);

  logic [W-1:0] mem [DEPTH];

  // Storage array write and registered read.
  // NOTE: the array and its read register have no reset; a reset would stop
  // this mapping onto a RAM macro, and every entry is rewritten by a first beat
  // before it is ever read for accumulation.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/psum_acc.sv
// Partial-sum accumulator. Stage S0 accepts a beat and reads the running sum
// for its pixel; stage S1 adds the beat to it and either writes it back or,
// on the last input-channel group, requantizes to int8 into the omap output
// register. Every stage stalls while the output register is full and the
// omap side is not ready.
module psum_acc
  import psum_acc_pkg::*;
#(
  parameter int PSUM_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  psum_acc_if.slave   bus,
  input  logic [4:0]  quant_shift,
  input  logic        relu_en,
  output logic        acc_done,
  output logic [15:0] beat_cnt
);

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [PSUM_W:0]   wide_t;

  localparam wide_t SAT_MAX = wide_t'(INT8_MAX);
  localparam wide_t SAT_MIN = wide_t'(INT8_MIN);

  // Round half up, arithmetic shift, optional ReLU, saturate to int8. One
  // extra bit keeps the rounding add from overflowing.
  function automatic logic [7:0] requant(input psum_t acc, input logic [4:0] sh,
                                         input logic relu);
    wide_t ext;
    wide_t rnd;
    wide_t r;
    ext = wide_t'(acc);
    rnd = '0;
    if (sh != 5'd0) rnd = wide_t'(1) << (sh - 5'd1);
    r = (ext + rnd) >>> sh;
    if (relu && r[PSUM_W]) r = '0;
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return r[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        en_q,       en_d;
  logic        st_vld_q,   st_vld_d;
  beat_info_t  st_info_q,  st_info_d;
  beat_data_t  st_data_q,  st_data_d;
  logic        fwd_q,      fwd_d;
  psum_t       fwd_data_q, fwd_data_d;
  logic        out_vld_q,  out_vld_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_eoc_q,  out_eoc_d;
  logic [15:0] cnt_q,      cnt_d;

  // ---------------------------------------------------------------------------
  // Handshake and input decode
  // ---------------------------------------------------------------------------
  logic        adv;
  logic        rdy;
  logic        accept;
  beat_info_t  in_info;
  beat_data_t  in_data;
  logic        unused_rsvd;

  assign adv         = !(out_vld_q && !bus.omap_wrdy);
  // en_q keeps the input closed until the first clock after reset release.
  assign rdy         = adv && en_q;
  assign accept      = bus.mac_array2psum_acc_vld && rdy;
  assign in_info     = decode_info(bus.mac_array2psum_acc_info[EOC_BIT:0]);
  assign in_data     = decode_data(bus.mac_array2psum_acc_data);
  assign unused_rsvd = ^bus.mac_array2psum_acc_info[INFO_W-1:EOC_BIT+1];

  // ---------------------------------------------------------------------------
  // Buffer
  // ---------------------------------------------------------------------------
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  psum_t             rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  psum_t             wr_data;

  // Pixel indices beyond the buffer alias by truncation.
  assign rd_en   = accept;
  assign rd_addr = in_info.pix[ADDR_W-1:0];

  psum_buf #(
    .W      (PSUM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // S0: capture an accepted beat, and remember whether the buffer read it
  // issued collided with this cycle's S1 write so S1 uses the new value.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    en_d       = 1'b1;
    st_vld_d   = st_vld_q;
    st_info_d  = st_info_q;
    st_data_d  = st_data_q;
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    if (adv) begin
      st_vld_d = accept;
      if (accept) begin
        st_info_d  = in_info;
        st_data_d  = in_data;
        fwd_d      = wr_en && (wr_addr == rd_addr);
        fwd_data_d = wr_data;
      end
    end
  end

  // S1: add the beat to the running sum; write it back, or hand it to the
  // output register on the last group.
  psum_t beat_sum;
  psum_t acc_prev;
  psum_t acc;
  logic  fire;
  logic  load;

  always_comb begin
    beat_sum = psum_t'($signed(st_data_q.p3))
             + psum_t'($signed(st_data_q.p1))
             + psum_t'($signed(st_data_q.id));
    acc_prev = fwd_q ? fwd_data_q : rd_data;
    acc      = st_info_q.first ? beat_sum : (acc_prev + beat_sum);
    fire     = st_vld_q && adv;
    load     = fire && st_info_q.last;
    wr_en    = fire && !st_info_q.last;
    wr_addr  = st_info_q.pix[ADDR_W-1:0];
    wr_data  = acc;
  end

  // Output register: load on a last beat, drop on handshake; a load in the
  // handshake cycle keeps it valid with the new result.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_eoc_d  = out_eoc_q;
    cnt_d      = cnt_q + 16'(accept);
    if (load) begin
      out_vld_d  = 1'b1;
      out_addr_d = omap_addr(st_info_q.och, st_info_q.pix);
      out_data_d = requant(acc, quant_shift, relu_en);
      out_eoc_d  = st_info_q.eoc;
    end else if (out_vld_q && bus.omap_wrdy) begin
      out_vld_d  = 1'b0;
    end
  end

  // All pipeline and output state; reset discards in-flight beats.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      st_vld_q   <= 1'b0;
      st_info_q  <= '0;
      st_data_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_eoc_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      en_q       <= en_d;
      st_vld_q   <= st_vld_d;
      st_info_q  <= st_info_d;
      st_data_q  <= st_data_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_eoc_q  <= out_eoc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.mac_array2psum_acc_rdy = rdy;
  assign bus.omap_wvld              = out_vld_q;
  assign bus.omap_waddr             = out_addr_q;
  assign bus.omap_wdata             = out_data_q;
  assign acc_done                   = out_vld_q && bus.omap_wrdy && out_eoc_q;
  assign beat_cnt                   = cnt_q;

endmodule
